// File: rtl/tron_grid_renderer_if.sv
// Cell-write port between the game logic and the arena renderer.
// The game logic drives a cell coordinate and code. The renderer answers
// with wr_ready, and a write commits in any cycle where both are high.
interface tron_grid_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_x;
  logic [6:0] wr_y;
  logic [1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/tron_grid_renderer.sv
// Light-cycle arena pixel stage.
// The arena is a grid of 2-bit cells held in a single-port RAM. During active
// video the RAM serves display reads. During blanking it serves the clear
// sweep and then the external cell writes. RGB leaves two cycles after the
// pixel coordinate arrives, and HS, VS and blank are delayed to match.
module tron_grid_renderer #(
  parameter int          GRID_W     = 100,
  parameter int          GRID_H     = 75,
  parameter int          CELL_SHIFT = 3,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] P1_COLOR   = 12'h0FF,
  parameter logic [11:0] P2_COLOR   = 12'hF80,
  parameter logic [11:0] WALL_COLOR = 12'hFFF
) (
  input  logic                   clock_40MHz,
  input  logic                   reset,
  input  logic [9:0]             row,
  input  logic [9:0]             col,
  input  logic                   blank_in,
  input  logic                   HS_in,
  input  logic                   VS_in,
  tron_grid_renderer_if.slave    wr,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic                   clear_done,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   HS,
  output logic                   VS,
  output logic                   blank
);

  localparam int          CELLS     = GRID_W * GRID_H;
  localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [12:0] sweep_addr;
  logic [12:0] sweep_next;

  logic [9:0]  cell_y;
  logic [9:0]  cell_x;
  logic [12:0] rd_addr;
  logic [12:0] wr_addr;
  logic        wr_in_range;

  logic        ram_we;
  logic [12:0] ram_addr;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic        wr_ready_c;
  logic        sweep_last;

  logic        hs_d1;
  logic        vs_d1;
  logic        blank_d1;

  logic [1:0]  mem [CELLS];

  // Map a cell code onto its 12-bit colour.
  function automatic logic [11:0] code_to_rgb(input logic [1:0] code);
    case (code)
      2'd0:    code_to_rgb = BG_COLOR;
      2'd1:    code_to_rgb = P1_COLOR;
      2'd2:    code_to_rgb = P2_COLOR;
      2'd3:    code_to_rgb = WALL_COLOR;
      default: code_to_rgb = BG_COLOR;
    endcase
  endfunction

  assign cell_y      = row >> CELL_SHIFT;
  assign cell_x      = col >> CELL_SHIFT;
  assign rd_addr     = 13'(cell_y) * 13'(GRID_W) + 13'(cell_x);
  assign wr_addr     = 13'(wr.wr_y) * 13'(GRID_W) + 13'(wr.wr_x);
  assign wr_in_range = (wr.wr_x < 7'(GRID_W)) && (wr.wr_y < 7'(GRID_H));

  assign wr.wr_ready = wr_ready_c;
  assign clear_busy  = (state == CLEAR);

  // Sweep FSM state register. Reset always starts a fresh clear from cell 0.
  always_ff @(posedge clock_40MHz or negedge reset) begin
    if (!reset) begin
      state      <= CLEAR;
      sweep_addr <= 13'd0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_next;
    end
  end

  // Sweep FSM next state. The sweep advances only on blank cycles.
  always_comb begin
    state_next = state;
    sweep_next = sweep_addr;
    case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          sweep_next = 13'd0;
        end else begin
          state_next = IDLE;
          sweep_next = sweep_addr;
        end
      end
      CLEAR: begin
        if (blank_in && (sweep_addr == LAST_ADDR)) begin
          state_next = IDLE;
          sweep_next = 13'd0;
        end else if (blank_in) begin
          state_next = CLEAR;
          sweep_next = sweep_addr + 13'd1;
        end else begin
          state_next = CLEAR;
          sweep_next = sweep_addr;
        end
      end
      default: begin
        state_next = CLEAR;
        sweep_next = 13'd0;
      end
    endcase
  end

  // RAM arbitration: display read first, then the sweep, then external writes.
  always_comb begin
    ram_we     = 1'b0;
    ram_addr   = rd_addr;
    ram_wdata  = 2'b00;
    wr_ready_c = 1'b0;
    sweep_last = 1'b0;
    if (blank_in) begin
      case (state)
        IDLE: begin
          wr_ready_c = ~clear_req;
          if (wr.wr_valid && !clear_req && wr_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr.wr_data;
          end else begin
            ram_we    = 1'b0;
            ram_addr  = rd_addr;
          end
        end
        CLEAR: begin
          ram_we     = 1'b1;
          ram_addr   = sweep_addr;
          ram_wdata  = 2'b00;
          sweep_last = (sweep_addr == LAST_ADDR);
        end
        default: begin
          ram_we = 1'b0;
        end
      endcase
    end else begin
      ram_we   = 1'b0;
      ram_addr = rd_addr;
    end
  end

  // Completion pulse, one cycle after the last sweep write.
  always_ff @(posedge clock_40MHz or negedge reset) begin
    if (!reset) begin
      clear_done <= 1'b0;
    end else begin
      clear_done <= sweep_last;
    end
  end

  // Arena RAM: single port, synchronous read. The contents are not reset.
  always_ff @(posedge clock_40MHz) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Two-stage delay of the sync and blank signals, matching the RAM latency.
  always_ff @(posedge clock_40MHz or negedge reset) begin
    if (!reset) begin
      hs_d1    <= 1'b1;
      vs_d1    <= 1'b1;
      blank_d1 <= 1'b1;
      HS       <= 1'b1;
      VS       <= 1'b1;
      blank    <= 1'b1;
    end else begin
      hs_d1    <= HS_in;
      vs_d1    <= VS_in;
      blank_d1 <= blank_in;
      HS       <= hs_d1;
      VS       <= vs_d1;
      blank    <= blank_d1;
    end
  end

  // Colour lookup stage. Blanked pixels are forced black.
  always_ff @(posedge clock_40MHz or negedge reset) begin
    if (!reset) begin
      {red, green, blue} <= 12'h000;
    end else if (blank_d1) begin
      {red, green, blue} <= 12'h000;
    end else begin
      {red, green, blue} <= code_to_rgb(ram_rdata);
    end
  end

endmodule

// File: doc/tron_grid_renderer.md
Name: tron_grid_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes row, col, blank, HS and VS, and holds the light-cycle arena as a 100x75 grid of 8x8-pixel cells in on-chip RAM.
- Outputs 12-bit RGB aligned with delayed sync signals.
- Game logic writes cells through a valid/ready port; a sweep engine clears the whole grid.

Parameters:
- GRID_W, 100, cells per row (800 px / 8).
- GRID_H, 75, cell rows (600 px / 8).
- CELL_SHIFT, 3, log2 of cell size in pixels.
- BG_COLOR, 12'h000, RGB for an empty cell.
- P1_COLOR, 12'h0FF, RGB for a player-1 trail.
- P2_COLOR, 12'hF80, RGB for a player-2 trail.
- WALL_COLOR, 12'hFFF, RGB for a wall.

Ports:
- clock_40MHz  input  1  pixel clock.
- reset  input  1  asynchronous, active-low reset.
- row  input  10  display row from VGA timing.
- col  input  10  display column from VGA timing.
- blank_in  input  1  high outside the visible region.
- HS_in  input  1  horizontal sync, active low.
- VS_in  input  1  vertical sync, active low.
- wr_valid  input  1  cell write request.
- wr_ready  output  1  write accepted this cycle when high together with wr_valid.
- wr_x  input  7  cell column, 0..GRID_W-1.
- wr_y  input  7  cell row, 0..GRID_H-1.
- wr_data  input  2  cell code: 0 empty, 1 P1, 2 P2, 3 wall.
- clear_req  input  1  single-cycle pulse; start a full-grid clear.
- clear_busy  output  1  high while a clear sweep is in progress.
- clear_done  output  1  one-cycle pulse when the sweep finishes.
- red  output  4  pixel red.
- green  output  4  pixel green.
- blue  output  4  pixel blue.
- HS  output  1  HS_in delayed 2 cycles.
- VS  output  1  VS_in delayed 2 cycles.
- blank  output  1  blank_in delayed 2 cycles.

Behaviour:
- Reset values:
  - RGB = 0; HS = 1; VS = 1; blank = 1.
  - wr_ready = 0; clear_done = 0.
  - clear_busy = 1: the FSM enters CLEAR with sweep address 0, so the grid is cleared after every reset.
- RAM: 7500 x 2 bits, single port, synchronous read with 1-cycle latency. Contents are not reset.
- Address: GRID_W*y + x, 13 bits.
  - Read side: y = row>>CELL_SHIFT, x = col>>CELL_SHIFT.
- Read pipeline, fixed 2-cycle latency:
  - S0: form the address; issue the RAM read when blank_in = 0.
  - S1: RAM data valid.
  - S2: register the colour lookup. HS, VS and blank pass through a 2-stage shift register, so an input pixel at cycle t appears on the outputs at t+2.
  - Registered blank = 1 forces RGB = 0 regardless of RAM data.
- Port arbitration, one RAM access per cycle, priority highest first:
  - display read (blank_in = 0),
  - clear sweep,
  - external write.
- Writes and the sweep use the RAM only while blank_in = 1.
- wr_ready = blank_in & (state == IDLE). The write commits in the handshake cycle. Holding wr_valid with stable data during active video stalls until the next blank.
- Out-of-range write (wr_x >= GRID_W or wr_y >= GRID_H): the handshake completes but the RAM is not written.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_req; sweep address is set to 0. clear_req takes precedence over wr_valid in the same cycle, and wr_ready is 0 that cycle.
  - In CLEAR, each cycle with blank_in = 1: write 0 to the sweep address, then increment it. Cycles with blank_in = 0 hold the address.
  - After writing address 7499: go to IDLE, pulse clear_done in the next cycle, drop clear_busy.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
- Reset asserted mid-sweep or mid-write: asynchronously returns to the CLEAR state at address 0. No partial-write guarantee applies.
- Colour map: code 0 → BG_COLOR, 1 → P1_COLOR, 2 → P2_COLOR, 3 → WALL_COLOR. Bits [11:8] drive red, [7:4] green, [3:0] blue.

Test Plan:
- Reset, then run the VGA timing → clear_busy = 1 until 7500 blank cycles have elapsed, then a single clear_done pulse. The next frame shows RGB = 000 on every visible pixel, and HS/VS/blank match the inputs delayed by 2.
- During blank, write x = 5, y = 2, data = 1 → at row 16..23, col 40..47, RGB = 0FF appears 2 cycles after the matching row/col input; neighbouring cells stay 000.
- Assert wr_valid (x = 99, y = 74, data = 3) at the start of active video → wr_ready stays 0 until blank_in rises; the handshake then completes, and row 599, col 799 shows FFF.
- Write x = 100, y = 0, data = 2 → the handshake completes; no cell changes (full-frame compare against the previous frame).
- Assert clear_req and wr_valid in the same blank cycle → the write is not accepted; the sweep runs to completion; the write is accepted after clear_done, and its cell is the only non-background cell.
- Assert reset mid-sweep (address near 3000), then release it → clear_busy = 1, the sweep restarts at 0, and clear_done arrives 7500 blank cycles after release.
